// File: rtl/alu_wide_seq.sv
// alu_wide_seq: two-pass 16-bit arithmetic sequencer (ADD HL,rr / ADD SP,e / INC rr / DEC rr).
// The low byte is added in one pass and the high byte in the next, with the carry chained between them.
// The 16-bit result and the flags are presented for one cycle in DONE.
// Ports:
//   CLK        clock, rising edge
//   nRESET     asynchronous active-low reset
//   start      request, accepted only in IDLE when abort is low
//   op         00 ADD16, 01 ADDSPE, 10 INC16, 11 DEC16 (sampled with start)
//   opa, opb   operands (opb[7:0] = e for ADDSPE; opb ignored for INC16/DEC16)
//   abort      synchronous cancel; returns to IDLE with no done
//   busy       high in LOW, HIGH and DONE
//   done       one-cycle completion pulse
//   result     last completed 16-bit result, held between operations
//   flags_out  {Z,N,H,C} values, non-zero only in DONE
//   flags_we   {Z,N,H,C} write enables, non-zero only in DONE
module alu_wide_seq #(
  parameter int unsigned BYTE_W = 8
) (
  input  logic                  CLK,
  input  logic                  nRESET,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [2*BYTE_W-1:0]   opa,
  input  logic [2*BYTE_W-1:0]   opb,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [2*BYTE_W-1:0]   result,
  output logic [3:0]            flags_out,
  output logic [3:0]            flags_we
);

  localparam int unsigned W   = 2 * BYTE_W;
  localparam int unsigned NIB = BYTE_W / 2;

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;
  typedef enum logic [1:0] {OP_ADD16, OP_ADDSPE, OP_INC16, OP_DEC16} op_t;

  state_t              state;
  op_t                 op_q;
  logic [W-1:0]        a_q;
  logic [W-1:0]        b_q;
  logic                cin0;
  logic                c4, c8, c12, c16;
  logic [BYTE_W-1:0]   work_lo;

  logic [BYTE_W:0]     lo_sum;
  logic [BYTE_W:0]     hi_sum;
  logic                lo_nib_c;
  logic                hi_nib_c;

  always_comb begin
    lo_sum = {1'b0, a_q[BYTE_W-1:0]} + {1'b0, b_q[BYTE_W-1:0]} + {{BYTE_W{1'b0}}, cin0};
    hi_sum = {1'b0, a_q[W-1:BYTE_W]} + {1'b0, b_q[W-1:BYTE_W]} + {{BYTE_W{1'b0}}, c8};
    // Carry into the middle bit of a pass, recovered from sum ^ a ^ b at that bit.
    lo_nib_c = lo_sum[NIB] ^ a_q[NIB] ^ b_q[NIB];
    hi_nib_c = hi_sum[NIB] ^ a_q[BYTE_W+NIB] ^ b_q[BYTE_W+NIB];
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state   <= IDLE;
      op_q    <= OP_ADD16;
      a_q     <= '0;
      b_q     <= '0;
      cin0    <= 1'b0;
      c4      <= 1'b0;
      c8      <= 1'b0;
      c12     <= 1'b0;
      c16     <= 1'b0;
      work_lo <= '0;
      result  <= '0;
    end else if (abort) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            op_q  <= op_t'(op);
            a_q   <= opa;
            state <= LOW;
            unique case (op_t'(op))
              OP_ADD16:  begin b_q <= opb; cin0 <= 1'b0; end
              OP_ADDSPE: begin b_q <= {{BYTE_W{opb[BYTE_W-1]}}, opb[BYTE_W-1:0]}; cin0 <= 1'b0; end
              OP_INC16:  begin b_q <= '0; cin0 <= 1'b1; end
              OP_DEC16:  begin b_q <= '1; cin0 <= 1'b0; end
            endcase
          end
        end
        LOW: begin
          work_lo <= lo_sum[BYTE_W-1:0];
          c8      <= lo_sum[BYTE_W];
          c4      <= lo_nib_c;
          state   <= HIGH;
        end
        HIGH: begin
          c16    <= hi_sum[BYTE_W];
          c12    <= hi_nib_c;
          // Result commits only here, so an abort in LOW/HIGH leaves the previous value intact.
          result <= {hi_sum[BYTE_W-1:0], work_lo};
          state  <= DONE;
        end
        DONE: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_comb begin
    flags_out = '0;
    flags_we  = '0;
    if (state == DONE) begin
      unique case (op_q)
        OP_ADD16: begin
          flags_out = {1'b0, 1'b0, c12, c16};
          flags_we  = 4'b0111;
        end
        OP_ADDSPE: begin
          flags_out = {1'b0, 1'b0, c4, c8};
          flags_we  = 4'b1111;
        end
        default: begin
          flags_out = '0;
          flags_we  = '0;
        end
      endcase
    end
  end

endmodule
